// File: rtl/clint_pkg.sv
// Shared definitions for the multi-hart CLINT: register offsets, bus FSM states,
// AXI response codes and the byte-strobe merge helper.
package clint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_OFS     = 16'hBFF8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_WRESP, ST_RRESP} state_e;
    typedef enum logic [1:0] {REG_NONE, REG_MSIP, REG_MTIMECMP, REG_MTIME} reg_e;

    function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
        logic [63:0] r;
        r = old_v;
        for (int b = 0; b < 8; b++)
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/clint_axil_multihart_if.sv
// AXI4-Lite slave bundle (64-bit data) for the CLINT register port.
interface clint_axil_multihart_if #(parameter int ADDR_W = 64);

    logic              awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid, wready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              bvalid, bready;
    logic [1:0]        bresp;
    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid, rready;
    logic [63:0]       rdata;
    logic [1:0]        rresp;

    modport master (output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
                    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp);
    modport slave  (input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
                    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp);

endinterface

// File: rtl/clint_rtc_tick.sv
// mtime tick source: either an aclk prescaler or a synchronised rising edge of rtc_i.
module clint_rtc_tick #(
    parameter int USE_EXT_RTC = 0,
    parameter int RTC_DIV     = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rtc_i,
    output logic tick_o
);

    generate
        if (USE_EXT_RTC != 0) begin : g_ext
            logic [1:0] sync;
            logic       prev;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync <= '0;
                    prev <= 1'b0;
                end else begin
                    sync <= {sync[0], rtc_i};
                    prev <= sync[1];
                end
            end

            assign tick_o = sync[1] & ~prev;
        end else begin : g_int
            localparam int              CW   = (RTC_DIV > 1) ? $clog2(RTC_DIV) : 1;
            localparam logic [CW-1:0]   LAST = CW'(RTC_DIV - 1);
            logic [CW-1:0] cnt;
            logic          unused_rtc;

            always_ff @(posedge clk) begin
                if (!rst_n)           cnt <= '0;
                else if (cnt == LAST) cnt <= '0;
                else                  cnt <= cnt + 1'b1;
            end

            assign tick_o     = (cnt == LAST);
            assign unused_rtc = rtc_i;
        end
    endgenerate

endmodule

// File: rtl/clint_axil_multihart.sv
// Multi-hart CLINT: AXI4-Lite register port, 64-bit mtime, per-hart mtimecmp/msip,
// registered timer and software interrupt outputs.
module clint_axil_multihart
    import clint_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int NR_HARTS       = 1,
    parameter int USE_EXT_RTC    = 0,
    parameter int RTC_DIV        = 1
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   rtc_i,
    clint_axil_multihart_if.slave  s_axil,
    output logic [NR_HARTS-1:0]    timer_irq_o,
    output logic [NR_HARTS-1:0]    ipi_o
);

    localparam int          HIW = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1;
    localparam logic [31:0] NH  = 32'(NR_HARTS);

    typedef struct packed {
        reg_e           kind;
        logic [HIW-1:0] idx;
    } dec_t;

    function automatic dec_t decode(input logic [15:0] a);
        dec_t d;
        d.kind = REG_NONE;
        d.idx  = '0;
        if (a[15:14] == MSIP_BASE[15:14] && 32'(a[13:2]) < NH) begin
            d.kind = REG_MSIP;
            d.idx  = a[2 +: HIW];
        end else if (a[15:14] == MTIMECMP_BASE[15:14] && 32'(a[13:3]) < NH) begin
            d.kind = REG_MTIMECMP;
            d.idx  = a[3 +: HIW];
        end else if (a[15:3] == MTIME_OFS[15:3]) begin
            d.kind = REG_MTIME;
        end
        return d;
    endfunction

    state_e                     state;
    logic [63:0]                mtime;
    logic [NR_HARTS-1:0]        msip;
    logic [NR_HARTS-1:0][63:0]  mtimecmp;
    logic                       bvalid, rvalid;
    logic [1:0]                 bresp, rresp, rd_resp;
    logic [63:0]                rdata, rd_val;
    logic                       tick, wr_fire, rd_fire, msip_wen, msip_wbit;
    dec_t                       wdec, rdec;
    logic                       unused_addr;

    clint_rtc_tick #(.USE_EXT_RTC(USE_EXT_RTC), .RTC_DIV(RTC_DIV)) u_tick (
        .clk(aclk), .rst_n(aresetn), .rtc_i(rtc_i), .tick_o(tick)
    );

    // Writes need both channels in the same cycle; any pending write half blocks reads.
    assign wr_fire = aresetn && state == ST_IDLE && s_axil.awvalid && s_axil.wvalid;
    assign rd_fire = aresetn && state == ST_IDLE && s_axil.arvalid &&
                     !(s_axil.awvalid || s_axil.wvalid);

    assign s_axil.awready = wr_fire;
    assign s_axil.wready  = wr_fire;
    assign s_axil.arready = rd_fire;
    assign s_axil.bvalid  = bvalid;
    assign s_axil.bresp   = bresp;
    assign s_axil.rvalid  = rvalid;
    assign s_axil.rdata   = rdata;
    assign s_axil.rresp   = rresp;

    assign wdec      = decode(s_axil.awaddr[15:0]);
    assign rdec      = decode(s_axil.araddr[15:0]);
    assign msip_wen  = s_axil.awaddr[2] ? s_axil.wstrb[4]  : s_axil.wstrb[0];
    assign msip_wbit = s_axil.awaddr[2] ? s_axil.wdata[32] : s_axil.wdata[0];

    assign unused_addr = ^{s_axil.awaddr[AXI_ADDR_WIDTH-1:16], s_axil.araddr[AXI_ADDR_WIDTH-1:16],
                           s_axil.awaddr[1:0], s_axil.araddr[1:0]};

    always_comb begin
        rd_val  = '0;
        rd_resp = RESP_OKAY;
        case (rdec.kind)
            REG_MSIP:     rd_val = s_axil.araddr[2] ? {31'b0, msip[rdec.idx], 32'b0}
                                                    : {63'b0, msip[rdec.idx]};
            REG_MTIMECMP: rd_val = mtimecmp[rdec.idx];
            REG_MTIME:    rd_val = mtime;
            default:      rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            bvalid      <= 1'b0;
            rvalid      <= 1'b0;
            bresp       <= RESP_OKAY;
            rresp       <= RESP_OKAY;
            rdata       <= '0;
            mtime       <= '0;
            msip        <= '0;
            mtimecmp    <= '1;
            timer_irq_o <= '0;
            ipi_o       <= '0;
        end else begin
            if (tick) mtime <= mtime + 64'd1;
            for (int h = 0; h < NR_HARTS; h++)
                timer_irq_o[h] <= (mtime >= mtimecmp[h]);
            ipi_o <= msip;

            case (state)
                ST_IDLE: begin
                    if (wr_fire) begin
                        bvalid <= 1'b1;
                        bresp  <= (wdec.kind == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
                        state  <= ST_WRESP;
                        // Later assignment: a bus write to mtime overrides a same-cycle tick.
                        case (wdec.kind)
                            REG_MSIP:     if (msip_wen) msip[wdec.idx] <= msip_wbit;
                            REG_MTIMECMP: mtimecmp[wdec.idx] <= strb_merge(mtimecmp[wdec.idx],
                                                                   s_axil.wdata, s_axil.wstrb);
                            REG_MTIME:    mtime <= strb_merge(mtime, s_axil.wdata, s_axil.wstrb);
                            default: ;
                        endcase
                    end else if (rd_fire) begin
                        rvalid <= 1'b1;
                        rdata  <= rd_val;
                        rresp  <= rd_resp;
                        state  <= ST_RRESP;
                    end
                end
                ST_WRESP: if (s_axil.bready) begin
                    bvalid <= 1'b0;
                    state  <= ST_IDLE;
                end
                ST_RRESP: if (s_axil.rready) begin
                    rvalid <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clint_axil_multihart.sv
// Scoreboarded bench: u_int (4 harts, prescale 4) and u_ext (4 harts, external RTC).
module tb_clint_axil_multihart;
    import clint_pkg::*;

    typedef struct {
        bit          is_rd;
        logic [63:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic rstn_a = 1'b0, rstn_e = 1'b0, rtc = 1'b0;
    logic [3:0] irq_a, ipi_a, irq_e, ipi_e;

    clint_axil_multihart_if #(.ADDR_W(64)) bus [2] ();

    logic        awv[2], wv[2], bre[2], arv[2], rre[2];
    logic [63:0] awa[2], wd[2], ara[2];
    logic [7:0]  ws[2];
    logic        awrdy[2], wrdy[2], arrdy[2], bvld[2], rvld[2];
    logic [1:0]  bresp_t[2], rresp_t[2];
    logic [63:0] rdata_t[2];

    for (genvar p = 0; p < 2; p++) begin : g_bus
        assign bus[p].awvalid = awv[p];
        assign bus[p].awaddr  = awa[p];
        assign bus[p].wvalid  = wv[p];
        assign bus[p].wdata   = wd[p];
        assign bus[p].wstrb   = ws[p];
        assign bus[p].bready  = bre[p];
        assign bus[p].arvalid = arv[p];
        assign bus[p].araddr  = ara[p];
        assign bus[p].rready  = rre[p];
        assign awrdy[p]   = bus[p].awready;
        assign wrdy[p]    = bus[p].wready;
        assign arrdy[p]   = bus[p].arready;
        assign bvld[p]    = bus[p].bvalid;
        assign bresp_t[p] = bus[p].bresp;
        assign rvld[p]    = bus[p].rvalid;
        assign rdata_t[p] = bus[p].rdata;
        assign rresp_t[p] = bus[p].rresp;
    end

    clint_axil_multihart #(.AXI_ADDR_WIDTH(64), .NR_HARTS(4), .USE_EXT_RTC(0), .RTC_DIV(4)) u_int (
        .aclk(aclk), .aresetn(rstn_a), .rtc_i(1'b0), .s_axil(bus[0]),
        .timer_irq_o(irq_a), .ipi_o(ipi_a)
    );

    clint_axil_multihart #(.AXI_ADDR_WIDTH(64), .NR_HARTS(4), .USE_EXT_RTC(1), .RTC_DIV(1)) u_ext (
        .aclk(aclk), .aresetn(rstn_e), .rtc_i(rtc), .s_axil(bus[1]),
        .timer_irq_o(irq_e), .ipi_o(ipi_e)
    );

    // Edges seen by u_int since reset release; with prescale 4, mtime ticks on every 4th edge.
    int cyc = 0;
    always @(posedge aclk) cyc <= rstn_a ? cyc + 1 : 0;

    int nchk = 0, nerr = 0;
    exp_t qa[$], qe[$];
    logic [63:0] m_base = 64'h0;
    int          m_e = 0;

    function automatic logic [63:0] mt(input int k);
        return m_base + 64'(k / 4 - m_e / 4);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input int p, input bit is_rd, input logic [63:0] d, input logic [1:0] r);
        exp_t e;
        e.is_rd = is_rd; e.data = d; e.resp = r;
        if (p == 0) qa.push_back(e); else qe.push_back(e);
    endtask

    task automatic chk_pop(input int p, input bit is_rd, input logic [63:0] d, input logic [1:0] r);
        exp_t e;
        nchk++;
        if ((p == 0 && qa.size() == 0) || (p == 1 && qe.size() == 0)) begin
            nerr++;
            $display("FAIL unexpected_resp port%0d: got rd=%0d data=%h resp=%0d expected none",
                     p, is_rd, d, r);
        end else begin
            if (p == 0) e = qa.pop_front(); else e = qe.pop_front();
            if (e.is_rd !== is_rd || e.data !== d || e.resp !== r) begin
                nerr++;
                $display("FAIL resp port%0d: got rd=%0d data=%h resp=%0d expected rd=%0d data=%h resp=%0d",
                         p, is_rd, d, r, e.is_rd, e.data, e.resp);
            end
        end
    endtask

    // Monitor: compares every completed B/R handshake against the expectation queue.
    always begin
        @(negedge aclk);
        #2;
        for (int p = 0; p < 2; p++) begin
            if (bvld[p] && bre[p]) chk_pop(p, 1'b0, 64'h0, bresp_t[p]);
            if (rvld[p] && rre[p]) chk_pop(p, 1'b1, rdata_t[p], rresp_t[p]);
        end
    end

    task automatic do_wr(input int p, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                         input logic [1:0] r, input bit expect_resp, output int e);
        bit ok = 1'b0;
        awv[p] = 1'b1; wv[p] = 1'b1; awa[p] = a; wd[p] = d; ws[p] = s;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (awrdy[p] && wrdy[p]) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
        e = cyc + 1;
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL wr_timeout port%0d addr %h: got no awready expected awready", p, a);
        end else if (expect_resp) push(p, 1'b0, 64'h0, r);
        @(negedge aclk);
        awv[p] = 1'b0; wv[p] = 1'b0;
    endtask

    task automatic do_rd(input int p, input logic [63:0] a, input logic [63:0] d,
                         input logic [1:0] r, input bit use_time);
        bit ok = 1'b0;
        arv[p] = 1'b1; ara[p] = a;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (arrdy[p]) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL rd_timeout port%0d addr %h: got no arready expected arready", p, a);
        end else push(p, 1'b1, use_time ? mt(cyc) : d, r);
        @(negedge aclk);
        arv[p] = 1'b0;
    endtask

    initial begin
        int  e;
        bit  ok;
        for (int p = 0; p < 2; p++) begin
            awv[p] = 0; wv[p] = 0; arv[p] = 0; bre[p] = 1; rre[p] = 1;
            awa[p] = '0; wd[p] = '0; ara[p] = '0; ws[p] = '0;
        end
        repeat (3) @(negedge aclk);
        chk("rst_irq", 64'(irq_a), 64'h0);
        chk("rst_ipi", 64'(ipi_a), 64'h0);
        chk("rst_bvalid", 64'(bvld[0]), 64'h0);
        chk("rst_rvalid", 64'(rvld[0]), 64'h0);
        rstn_a = 1'b1;
        rstn_e = 1'b1;

        // Reset value of mtimecmp[1]
        do_rd(0, 64'h4008, 64'hFFFF_FFFF_FFFF_FFFF, RESP_OKAY, 1'b0);

        // Timer compare on hart 2: mtime reaches 10 after 40 edges, irq one edge later
        do_wr(0, 64'h4010, 64'd10, 8'hFF, RESP_OKAY, 1'b1, e);
        while (cyc < 40) @(negedge aclk);
        chk("irq_before", 64'(irq_a), 64'h0);
        @(negedge aclk);
        chk("irq_set", 64'(irq_a), 64'(4'b0100));
        do_rd(0, 64'hBFF8, 64'h0, RESP_OKAY, 1'b1);
        do_wr(0, 64'h4010, 64'd100, 8'hFF, RESP_OKAY, 1'b1, e);
        chk("irq_hold", 64'(irq_a), 64'(4'b0100));
        @(negedge aclk);
        chk("irq_clear", 64'(irq_a), 64'h0);

        // msip[3] lives in the upper lane
        do_wr(0, 64'h000C, 64'h1_0000_0000, 8'hF0, RESP_OKAY, 1'b1, e);
        chk("ipi_latency", 64'(ipi_a), 64'h0);
        @(negedge aclk);
        chk("ipi_set", 64'(ipi_a), 64'(4'b1000));
        do_wr(0, 64'h000C, 64'h0, 8'h0F, RESP_OKAY, 1'b1, e);
        @(negedge aclk);
        chk("ipi_masked", 64'(ipi_a), 64'(4'b1000));
        do_rd(0, 64'h000C, 64'h1_0000_0000, RESP_OKAY, 1'b0);
        do_rd(0, 64'h0008, 64'h0, RESP_OKAY, 1'b0);
        do_rd(0, 64'h0010, 64'h0, RESP_SLVERR, 1'b0);
        do_wr(0, 64'h000C, 64'h0, 8'hF0, RESP_OKAY, 1'b1, e);
        @(negedge aclk);
        chk("ipi_clear", 64'(ipi_a), 64'h0);

        // Partial write to mtimecmp[3], unmapped write
        do_wr(0, 64'h4018, 64'h0, 8'h0F, RESP_OKAY, 1'b1, e);
        do_rd(0, 64'h4018, 64'hFFFF_FFFF_0000_0000, RESP_OKAY, 1'b0);
        do_wr(0, 64'h5000, 64'h1, 8'hFF, RESP_SLVERR, 1'b1, e);

        // mtime write lands on a tick edge (edge count multiple of 4): tick lost, then wrap
        @(negedge aclk);
        while (cyc % 4 != 3) @(negedge aclk);
        do_wr(0, 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, RESP_OKAY, 1'b1, e);
        m_base = 64'hFFFF_FFFF_FFFF_FFFE;
        m_e    = e;
        for (int i = 0; i < 4; i++) begin
            do_rd(0, 64'hBFF8, 64'h0, RESP_OKAY, 1'b1);
            repeat (3) @(negedge aclk);
        end

        // AW early, W two cycles later, AR held throughout: write first, then the read
        push(0, 1'b0, 64'h0, RESP_OKAY);
        push(0, 1'b1, 64'h0, RESP_SLVERR);
        arv[0] = 1'b1; ara[0] = 64'h4020;
        awv[0] = 1'b1; awa[0] = 64'h4000; wd[0] = 64'h1234; ws[0] = 8'hFF; wv[0] = 1'b0;
        repeat (2) begin
            #1;
            chk("ar_blocked", 64'(arrdy[0]), 64'h0);
            chk("aw_alone", 64'(awrdy[0]), 64'h0);
            @(negedge aclk);
        end
        wv[0] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (awrdy[0]) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
        chk("aw_w_joint", 64'(ok), 64'h1);
        chk("ar_yield", 64'(arrdy[0]), 64'h0);
        @(negedge aclk);
        awv[0] = 1'b0; wv[0] = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (arrdy[0]) begin ok = 1'b1; break; end
            @(negedge aclk);
        end
        chk("ar_after_w", 64'(ok), 64'h1);
        @(negedge aclk);
        arv[0] = 1'b0;

        // External RTC: five rising edges, slow relative to aclk
        for (int i = 0; i < 5; i++) begin
            rtc = 1'b1; repeat (3) @(negedge aclk);
            rtc = 1'b0; repeat (4) @(negedge aclk);
        end
        repeat (2) @(negedge aclk);
        do_rd(1, 64'hBFF8, 64'd5, RESP_OKAY, 1'b0);

        // bvalid held while bready low; reset mid-response drops it
        bre[1] = 1'b0;
        do_wr(1, 64'h4000, 64'h77, 8'hFF, RESP_OKAY, 1'b0, e);
        for (int i = 0; i < 7; i++) begin
            rtc = (i < 3);
            chk("bvalid_hold", 64'(bvld[1]), 64'h1);
            @(negedge aclk);
        end
        rtc = 1'b0;
        rstn_e = 1'b0;
        @(negedge aclk);
        chk("bvalid_rst", 64'(bvld[1]), 64'h0);
        chk("irq_ext_rst", 64'(irq_e), 64'h0);
        rstn_e = 1'b1;
        bre[1] = 1'b1;
        repeat (2) @(negedge aclk);
        do_rd(1, 64'hBFF8, 64'h0, RESP_OKAY, 1'b0);
        do_rd(1, 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, RESP_OKAY, 1'b0);

        for (int i = 0; i < 32; i++) begin
            if (qa.size() == 0 && qe.size() == 0) break;
            @(negedge aclk);
        end
        chk("queue_drained", 64'(qa.size() + qe.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
